piso_tx_sched: RTL



---
 rtl/piso_tx_sched.sv | 119 +++++++++++
 1 files changed

// File: rtl/piso_tx_sched.sv
// Round-robin scheduler in front of a shared WIDTH-bit PISO shift register.
// Accepts one word per frame, then drives load / parallel-in and marks serial bit slots.
module piso_tx_sched #(
    parameter int N     = 2,
    parameter int WIDTH = 4,
    parameter int GAP   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N-1:0]               req_valid,
    input  logic [N*WIDTH-1:0]         req_data,
    output logic [N-1:0]               req_ready,
    output logic                       piso_load,
    output logic [WIDTH-1:0]           piso_pi,
    output logic                       bit_valid,
    output logic [$clog2(WIDTH)-1:0]   bit_idx,
    output logic [$clog2(N)-1:0]       grant_id,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int IW   = $clog2(WIDTH);
    localparam int GW   = $clog2(N);
    localparam int CMAX = (WIDTH > GAP) ? WIDTH : GAP;
    localparam int CW   = $clog2(CMAX);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [GW-1:0] ptr, ptr_d;
    logic [GW-1:0] sel, cand;
    logic          found;
    logic          accept;

    // Rotating search: first pending requester at or after the pointer wins.
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = GW'((int'(ptr) + k) % N);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign accept    = (state == S_IDLE) && found;
    assign req_ready = (accept && !reset) ? (N'(1) << sel) : '0;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ptr_d   = ptr;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_d = S_LOAD;
                    ptr_d   = (sel == GW'(N - 1)) ? '0 : sel + 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_SHIFT;
                cnt_d   = '0;
            end
            S_SHIFT: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_d = (GAP > 0) ? S_GAP : S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt == CW'(GAP - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            ptr        <= '0;
            piso_load  <= 1'b0;
            piso_pi    <= '0;
            bit_valid  <= 1'b0;
            bit_idx    <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            ptr   <= ptr_d;
            if (accept) begin
                piso_pi  <= req_data[sel*WIDTH +: WIDTH];
                grant_id <= sel;
            end
            piso_load  <= (state_d == S_LOAD);
            bit_valid  <= (state_d == S_SHIFT);
            bit_idx    <= (state_d == S_SHIFT) ? IW'(cnt_d) : '0;
            frame_done <= (state_d == S_SHIFT) && (cnt_d == CW'(WIDTH - 1));
            busy       <= (state_d != S_IDLE);
        end
    end

endmodule
